// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// Optional feature macro: MC_CTRL_ITYPE_EN (adds the EXECI state for addi/slti/ori/andi).
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
`ifdef MC_CTRL_ITYPE_EN
    EXECI  = 4'd9,
`endif
    FAULT  = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_I    = 7'b0010011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_ctrl;
    logic [1:0] result_src;
  } ctrl_t;

  // States that hold a memory request open and therefore run the timeout counter.
  function automatic logic is_wait_state(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Single shared memory port between the control unit (master) and the memory (slave).
interface multicycle_control_if;
  // mem_req is a Moore output of the master and never depends on mem_ready; an access
  // completes in the cycle where mem_req and mem_ready are both high. AdrSrc and MemWrite
  // are meaningful only while mem_req is high.
  logic mem_req;
  logic mem_ready;
  logic AdrSrc;
  logic MemWrite;

  modport master (
    output mem_req,
    output AdrSrc,
    output MemWrite,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  AdrSrc,
    input  MemWrite,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decoder: maps the main FSM's ALUop plus funct fields to an ALU control code.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [1:0] ALUop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       opb5,
  output logic [2:0] ALUctrl,
  output logic       illegal
);

  always_comb begin
    ALUctrl = ALU_ADD;
    illegal = 1'b0;
    case (ALUop)
      ALUOP_ADD: ALUctrl = ALU_ADD;
      ALUOP_SUB: ALUctrl = ALU_SUB;
      default: begin
        // Op[5] is clear for immediate forms, so addi with Instr[30] set stays an add.
        case (funct3)
          3'b000:  ALUctrl = (funct7b5 && opb5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUctrl = ALU_SLT;
          3'b110:  ALUctrl = ALU_OR;
          3'b111:  ALUctrl = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM (lw, sw, R-type add/sub/and/or/slt, beq) with memory timeout trap.
// Optional feature macro: MC_CTRL_ITYPE_EN enables addi/slti/ori/andi through the EXECI state.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          Instr,
  input  logic                 EQ,
  multicycle_control_if.master mem,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic [1:0]           ALUsrcA,
  output logic [1:0]           ALUsrcB,
  output logic [1:0]           ImmSrc,
  output logic [2:0]           ALUctrl,
  output logic [1:0]           Resultsrc,
  output logic [1:0]           fault,
  output state_t               dbg_state
);

  localparam int               CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_t           state, state_next;
  logic [CNT_W-1:0] tcnt;
  logic [1:0]       fault_q, fault_next;
  logic [1:0]       aluop;
  logic [2:0]       dec_ctrl;
  logic             dec_illegal;
  logic             timed_out;
  logic [6:0]       op;
  ctrl_t            ctrl;
  logic             unused_instr_bits;

  assign op                = Instr[6:0];
  assign unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};
  assign timed_out         = is_wait_state(state) && !mem.mem_ready && (tcnt == TO_MAX);

  alu_decoder u_alu_decoder (
    .ALUop    (aluop),
    .funct3   (Instr[14:12]),
    .funct7b5 (Instr[30]),
    .opb5     (op[5]),
    .ALUctrl  (dec_ctrl),
    .illegal  (dec_illegal)
  );

  // State register and sticky fault code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      fault_q <= FAULT_NONE;
    end else begin
      state <= state_next;
      if (state_next == FAULT && state != FAULT) begin
        fault_q <= fault_next;
      end
    end
  end

  // Counts stalled cycles of the current access; any state change restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (state_next != state) begin
      tcnt <= '0;
    end else if (is_wait_state(state) && !mem.mem_ready && tcnt != TO_MAX) begin
      tcnt <= tcnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    fault_next = FAULT_NONE;
    case (state)
      FETCH: begin
        if (mem.mem_ready) begin
          state_next = DECODE;
        end else if (timed_out) begin
          state_next = FAULT;
          fault_next = FAULT_TIMEOUT;
        end
      end
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_BEQ:       state_next = BEQ;
`ifdef MC_CTRL_ITYPE_EN
          OP_I:         state_next = EXECI;
`endif
          default: begin
            state_next = FAULT;
            fault_next = FAULT_ILLEGAL;
          end
        endcase
      end
      MEMADR: state_next = op[5] ? MEMWR : MEMRD;
      MEMRD: begin
        if (mem.mem_ready) begin
          state_next = MEMWB;
        end else if (timed_out) begin
          state_next = FAULT;
          fault_next = FAULT_TIMEOUT;
        end
      end
      MEMWB: state_next = FETCH;
      MEMWR: begin
        if (mem.mem_ready) begin
          state_next = FETCH;
        end else if (timed_out) begin
          state_next = FAULT;
          fault_next = FAULT_TIMEOUT;
        end
      end
      EXECR: begin
        if (dec_illegal) begin
          state_next = FAULT;
          fault_next = FAULT_ILLEGAL;
        end else begin
          state_next = ALUWB;
        end
      end
`ifdef MC_CTRL_ITYPE_EN
      EXECI: begin
        if (dec_illegal) begin
          state_next = FAULT;
          fault_next = FAULT_ILLEGAL;
        end else begin
          state_next = ALUWB;
        end
      end
`endif
      ALUWB:  state_next = FETCH;
      BEQ:    state_next = FETCH;
      FAULT:  state_next = FAULT;
      default: begin
        state_next = FAULT;
        fault_next = FAULT_ILLEGAL;
      end
    endcase
  end

  // ALU operation class per state; kept apart from the output decode that consumes dec_ctrl.
  always_comb begin
    aluop = ALUOP_ADD;
    case (state)
      EXECR: aluop = ALUOP_RTYPE;
`ifdef MC_CTRL_ITYPE_EN
      EXECI: aluop = ALUOP_ITYPE;
`endif
      BEQ:   aluop = ALUOP_SUB;
      default: aluop = ALUOP_ADD;
    endcase
  end

  always_comb begin
    ctrl          = '0;
    ctrl.alu_ctrl = dec_ctrl;
    case (state)
      FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem.mem_ready;
        ctrl.pc_write   = mem.mem_ready;
      end
      DECODE: begin
        // Branch target OldPC + ImmB lands in ALUOut for a possible beq.
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = IMM_B;
      end
      MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = op[5] ? IMM_S : IMM_I;
      end
      MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      MEMWB: begin
        ctrl.result_src = RES_MEM;
        ctrl.reg_write  = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
      end
`ifdef MC_CTRL_ITYPE_EN
      EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = IMM_I;
      end
`endif
      ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      BEQ: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = EQ;
      end
      default: ctrl = '0;
    endcase
  end

  // Asserting rst_n low drops every strobe at once, including an in-flight request.
  assign mem.mem_req  = rst_n & ctrl.mem_req;
  assign mem.AdrSrc   = rst_n & ctrl.adr_src;
  assign mem.MemWrite = rst_n & ctrl.mem_write;
  assign IRWrite      = rst_n & ctrl.ir_write;
  assign PCWrite      = rst_n & ctrl.pc_write;
  assign RegWrite     = rst_n & ctrl.reg_write;
  assign ALUsrcA      = rst_n ? ctrl.alu_src_a  : 2'b00;
  assign ALUsrcB      = rst_n ? ctrl.alu_src_b  : 2'b00;
  assign ImmSrc       = rst_n ? ctrl.imm_src    : 2'b00;
  assign ALUctrl      = rst_n ? ctrl.alu_ctrl   : 3'b000;
  assign Resultsrc    = rst_n ? ctrl.result_src : 2'b00;
  assign fault        = rst_n ? fault_q         : FAULT_NONE;
  assign dbg_state    = state;

endmodule
